// File: rtl/wb_port_arbiter_if.sv
// Write-back port bundle shared by the result producers and the arbiter.
// slave: arbiter side; master: producer/consumer side.
interface wb_port_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int SQN_W   = 7,
  parameter int TAG_W   = 7,
  parameter int DATA_W  = 32
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        IN_valid;
  logic [NUM_REQ*SQN_W-1:0]  IN_sqN;
  logic [NUM_REQ*TAG_W-1:0]  IN_tag;
  logic [NUM_REQ*DATA_W-1:0] IN_result;
  logic [NUM_REQ-1:0]        OUT_stall;
  logic                      IN_invalidate;
  logic [SQN_W-1:0]          IN_invalidateSqN;
  logic                      OUT_valid;
  logic [SQN_W-1:0]          OUT_sqN;
  logic [TAG_W-1:0]          OUT_tag;
  logic [DATA_W-1:0]         OUT_result;
  logic [IDX_W-1:0]          OUT_grantIdx;

  modport slave (
    input  IN_valid, IN_sqN, IN_tag, IN_result, IN_invalidate, IN_invalidateSqN,
    output OUT_stall, OUT_valid, OUT_sqN, OUT_tag, OUT_result, OUT_grantIdx
  );

  modport master (
    output IN_valid, IN_sqN, IN_tag, IN_result, IN_invalidate, IN_invalidateSqN,
    input  OUT_stall, OUT_valid, OUT_sqN, OUT_tag, OUT_result, OUT_grantIdx
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: one holding buffer per result producer, oldest
// sequence number wins the shared port each cycle, flush kills younger
// entries. Optional starvation guard enabled by defining
// WBARB_STARVE_GUARD_EN (default build: pure oldest-first).
module wb_port_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int SQN_W   = 7,
  parameter int TAG_W   = 7,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  wb
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] buf_valid;
  logic [SQN_W-1:0]   buf_sqn    [NUM_REQ];
  logic [TAG_W-1:0]   buf_tag    [NUM_REQ];
  logic [DATA_W-1:0]  buf_result [NUM_REQ];

  logic [NUM_REQ-1:0] kill_buf;
  logic [NUM_REQ-1:0] kill_in;
  logic [NUM_REQ-1:0] grant_oh;
  logic [NUM_REQ-1:0] stall;
  logic [NUM_REQ-1:0] capture;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [SQN_W-1:0]   best_sqn;

  logic               out_valid;
  logic [SQN_W-1:0]   out_sqn;
  logic [TAG_W-1:0]   out_tag;
  logic [DATA_W-1:0]  out_result;
  logic [IDX_W-1:0]   out_idx;

`ifdef WBARB_STARVE_GUARD_EN
  logic [2:0]         starve_cnt [NUM_REQ];
  logic               starve_hit;
`endif

  // a older than b in wrap-around sequence space: signed(a-b) < 0
  function automatic logic is_older(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] d;
    d = a - b;
    return d[SQN_W-1];
  endfunction

  // a younger than b: signed(a-b) > 0
  function automatic logic is_younger(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] d;
    d = a - b;
    return !d[SQN_W-1] && (d != '0);
  endfunction

  // Kill detection and grant selection (oldest-first, ties to lowest index)
  always_comb begin
    kill_buf    = '0;
    kill_in     = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    best_sqn    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      kill_buf[i] = wb.IN_invalidate && is_younger(buf_sqn[i], wb.IN_invalidateSqN);
      kill_in[i]  = wb.IN_invalidate &&
                    is_younger(wb.IN_sqN[i*SQN_W +: SQN_W], wb.IN_invalidateSqN);
      if (buf_valid[i] && !kill_buf[i] &&
          (!grant_valid || is_older(buf_sqn[i], best_sqn))) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(i);
        best_sqn    = buf_sqn[i];
      end
    end
`ifdef WBARB_STARVE_GUARD_EN
    // A starved requester overrides the age order; lowest starved index wins.
    starve_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!starve_hit && buf_valid[i] && !kill_buf[i] && starve_cnt[i][2]) begin
        starve_hit  = 1'b1;
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(i);
      end
    end
`endif
  end

  // Per-requester grant decode, back-pressure and capture enable
  always_comb begin
    grant_oh = '0;
    stall    = '0;
    capture  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = grant_valid && (grant_idx == IDX_W'(i));
      stall[i]    = buf_valid[i] && !grant_oh[i];
      capture[i]  = wb.IN_valid[i] && !stall[i] && !kill_in[i];
    end
  end

  // Buffer occupancy: fill on capture (refill wins over grant), drain on grant or kill
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (capture[i])
          buf_valid[i] <= 1'b1;
        else if (grant_oh[i] || kill_buf[i])
          buf_valid[i] <= 1'b0;
      end
    end
  end

  // Buffer payload, qualified by buf_valid so no reset needed
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (capture[i]) begin
        buf_sqn[i]    <= wb.IN_sqN[i*SQN_W +: SQN_W];
        buf_tag[i]    <= wb.IN_tag[i*TAG_W +: TAG_W];
        buf_result[i] <= wb.IN_result[i*DATA_W +: DATA_W];
      end
    end
  end

  // Output valid; the register is reloaded every cycle, so a killed entry
  // presented now is replaced by a non-killed grant (or nothing) at the next edge
  always_ff @(posedge clk) begin
    if (!rst)
      out_valid <= 1'b0;
    else
      out_valid <= grant_valid;
  end

  // Output payload of the granted buffer
  always_ff @(posedge clk) begin
    out_sqn    <= buf_sqn[grant_idx];
    out_tag    <= buf_tag[grant_idx];
    out_result <= buf_result[grant_idx];
    out_idx    <= grant_idx;
  end

`ifdef WBARB_STARVE_GUARD_EN
  // Starvation counters: count cycles spent full and not granted
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) starve_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!buf_valid[i] || grant_oh[i] || kill_buf[i])
          starve_cnt[i] <= '0;
        else if (starve_cnt[i] != '1)
          starve_cnt[i] <= starve_cnt[i] + 3'd1;
      end
    end
  end
`endif

  assign wb.OUT_stall    = stall;
  assign wb.OUT_valid    = out_valid;
  assign wb.OUT_sqN      = out_sqn;
  assign wb.OUT_tag      = out_tag;
  assign wb.OUT_result   = out_result;
  assign wb.OUT_grantIdx = out_idx;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: stimulus pushes expected write-backs
// (with the cycle they must appear in), a monitor pops and compares.
module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    logic [1:0]  idx;
    logic [6:0]  sqn;
    logic [6:0]  tag;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  wb_port_arbiter_if #(.NUM_REQ(3), .SQN_W(7), .TAG_W(7), .DATA_W(32)) bus ();

  wb_port_arbiter #(.NUM_REQ(3), .SQN_W(7), .TAG_W(7), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  // Monitor: every presented write-back must match the head of the scoreboard
  always @(negedge clk) begin
    if (mon_en && bus.OUT_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out: got idx=%0d sqN=%0d at cycle %0d, required no output",
                 bus.OUT_grantIdx, bus.OUT_sqN, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.OUT_grantIdx !== e.idx || bus.OUT_sqN !== e.sqn || bus.OUT_tag !== e.tag ||
            bus.OUT_result !== e.res || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL wb_out: got idx=%0d sqN=%0d tag=%0d res=%h cyc=%0d, required idx=%0d sqN=%0d tag=%0d res=%h cyc=%0d",
                   bus.OUT_grantIdx, bus.OUT_sqN, bus.OUT_tag, bus.OUT_result, cyc,
                   e.idx, e.sqn, e.tag, e.res, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.IN_valid         = '0;
    bus.IN_invalidate    = 1'b0;
    bus.IN_invalidateSqN = '0;
  endtask

  task automatic drive(input int i, input logic [6:0] s, input logic [6:0] t, input logic [31:0] r);
    bus.IN_valid[i]         = 1'b1;
    bus.IN_sqN[i*7 +: 7]    = s;
    bus.IN_tag[i*7 +: 7]    = t;
    bus.IN_result[i*32 +: 32] = r;
  endtask

  task automatic expect_wb(input logic [1:0] idx, input logic [6:0] s, input logic [6:0] t,
                           input logic [31:0] r, input int c);
    exp_t e;
    e.idx = idx; e.sqn = s; e.tag = t; e.res = r; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  initial begin
    int k;
    logic [6:0] s;
    bus.IN_sqN = '0;
    bus.IN_tag = '0;
    bus.IN_result = '0;
    idle();

    // Reset
    rst = 1'b0;
    repeat (2) tick();
    check("reset_valid", 32'(bus.OUT_valid), 0);
    rst = 1'b1;
    tick();
    check("reset_stall", 32'(bus.OUT_stall), 0);
    mon_en = 1'b1;

    // Single uncontended request: 2-cycle latency
    k = cyc;
    drive(0, 7'd5, 7'd3, 32'hDEADBEEF);
    expect_wb(2'd0, 7'd5, 7'd3, 32'hDEADBEEF, k + 2);
    tick();
    idle();
    repeat (4) tick();
    check("single_drain", sb.size(), 0);

    // Three simultaneous requests: oldest-first 1,2,0 with stall pattern
    k = cyc;
    drive(0, 7'd10, 7'd10, 32'h100);
    drive(1, 7'd8,  7'd8,  32'h200);
    drive(2, 7'd9,  7'd9,  32'h300);
    expect_wb(2'd1, 7'd8,  7'd8,  32'h200, k + 2);
    expect_wb(2'd2, 7'd9,  7'd9,  32'h300, k + 3);
    expect_wb(2'd0, 7'd10, 7'd10, 32'h100, k + 4);
    tick();
    idle();
    check("order_stall_c1", 32'(bus.OUT_stall), 32'b101);
    tick();
    check("order_stall_c2", 32'(bus.OUT_stall), 32'b001);
    tick();
    check("order_stall_c3", 32'(bus.OUT_stall), 32'b000);
    repeat (4) tick();
    check("order_drain", sb.size(), 0);

    // Wrap-around age: 126 is older than 1
    k = cyc;
    drive(0, 7'd126, 7'd1, 32'hAAAA);
    drive(1, 7'd1,   7'd2, 32'hBBBB);
    expect_wb(2'd0, 7'd126, 7'd1, 32'hAAAA, k + 2);
    expect_wb(2'd1, 7'd1,   7'd2, 32'hBBBB, k + 3);
    tick();
    idle();
    repeat (5) tick();
    check("wrap_drain", sb.size(), 0);

    // Flush: keep sqN <= 6, drop 9 and the in-flight input 7
    k = cyc;
    drive(0, 7'd3, 7'd30, 32'h3333);
    drive(1, 7'd6, 7'd31, 32'h6666);
    drive(2, 7'd9, 7'd32, 32'h9999);
    expect_wb(2'd0, 7'd3, 7'd30, 32'h3333, k + 2);
    expect_wb(2'd1, 7'd6, 7'd31, 32'h6666, k + 3);
    tick();
    idle();
    bus.IN_invalidate    = 1'b1;
    bus.IN_invalidateSqN = 7'd6;
    drive(0, 7'd7, 7'd33, 32'h7777);
    check("flush_stall_c1", 32'(bus.OUT_stall), 32'b110);
    tick();
    idle();
    check("flush_stall_c2", 32'(bus.OUT_stall), 32'b000);
    repeat (5) tick();
    check("flush_drain", sb.size(), 0);

    // Reset while all buffers are full: nothing emitted, stalls clear
    drive(0, 7'd20, 7'd20, 32'h2020);
    drive(1, 7'd21, 7'd21, 32'h2121);
    drive(2, 7'd22, 7'd22, 32'h2222);
    tick();
    idle();
    check("rstmid_stall_full", 32'(bus.OUT_stall), 32'b110);
    rst = 1'b0;
    tick();
    check("rstmid_valid", 32'(bus.OUT_valid), 0);
    check("rstmid_stall", 32'(bus.OUT_stall), 0);
    rst = 1'b1;
    tick();
    check("rstmid_valid_after", 32'(bus.OUT_valid), 0);
    repeat (5) tick();
    check("rstmid_drain", sb.size(), 0);

    // req2 held young while req0 keeps feeding older entries
    k = cyc;
`ifdef WBARB_STARVE_GUARD_EN
    for (int j = 0; j < 4; j++)
      expect_wb(2'd0, 7'(90 + j), 7'(90 + j), 32'hC000_0000 + 32'(90 + j), k + 2 + j);
    expect_wb(2'd2, 7'd100, 7'd50, 32'h5000, k + 6);
    for (int j = 0; j < 3; j++)
      expect_wb(2'd0, 7'(94 + j), 7'(94 + j), 32'hC000_0000 + 32'(94 + j), k + 7 + j);
`else
    for (int j = 0; j < 8; j++)
      expect_wb(2'd0, 7'(90 + j), 7'(90 + j), 32'hC000_0000 + 32'(90 + j), k + 2 + j);
    expect_wb(2'd2, 7'd100, 7'd50, 32'h5000, k + 10);
`endif
    s = 7'd90;
    drive(2, 7'd100, 7'd50, 32'h5000);
    for (int j = 0; j < 8; j++) begin
      logic took;
      drive(0, s, s, 32'hC000_0000 + 32'(s));
      took = !bus.OUT_stall[0];
      tick();
      bus.IN_valid[2] = 1'b0;
      if (took) s = s + 7'd1;
    end
    idle();
`ifdef WBARB_STARVE_GUARD_EN
    check("starve_accepted", 32'(s), 97);
`else
    check("starve_accepted", 32'(s), 98);
`endif
    repeat (6) tick();
    check("starve_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of result producers sharing the write-back port.
REQ-002 SHALL have parameter SQN_W, default 7, sequence-number width.
REQ-003 SHALL have parameter TAG_W, default 7, destination-tag width.
REQ-004 SHALL have parameter DATA_W, default 32, result width.
REQ-005 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port IN_valid  input  NUM_REQ  per-requester result valid.
REQ-008 SHALL have port IN_sqN  input  NUM_REQ*SQN_W  per-requester sequence number.
REQ-009 SHALL have port IN_tag  input  NUM_REQ*TAG_W  per-requester destination tag.
REQ-010 SHALL have port IN_result  input  NUM_REQ*DATA_W  per-requester result.
REQ-011 SHALL have port OUT_stall  output  NUM_REQ  per-requester back-pressure (the producer's wbStall).
REQ-012 SHALL have port IN_invalidate  input  1  flush request.
REQ-013 SHALL have port IN_invalidateSqN  input  SQN_W  last surviving sequence number.
REQ-014 SHALL have port OUT_valid  output  1  write-back valid.
REQ-015 SHALL have ports OUT_sqN/OUT_tag/OUT_result  output  SQN_W/TAG_W/DATA_W  granted entry fields.
REQ-016 SHALL have port OUT_grantIdx  output  $clog2(NUM_REQ)  index of the requester that produced OUT_*.

Function
REQ-017 SHALL hold one holding buffer per requester (valid, sqN, tag, result).
REQ-018 SHALL combinationally assert OUT_stall[i] iff buffer i is full and not granted this cycle.
REQ-019 SHALL capture input i into buffer i at the edge when IN_valid[i] && !OUT_stall[i]; a granted buffer is refilled in the same cycle.
REQ-020 SHALL grant each cycle the full, non-killed buffer with the oldest sqN; age compare is signed(a-b)<0 (wrap-safe); ties go to the lowest index.
REQ-021 SHALL register the granted entry into OUT_* at the edge; OUT_valid is 0 when no buffer was granted.
REQ-022 Latency: input capture to OUT_valid SHALL be exactly 2 cycles when uncontended; throughput 1 grant/cycle.
REQ-023 Kill rule: an entry is killed when IN_invalidate && signed(sqN - IN_invalidateSqN) > 0; sqN equal to IN_invalidateSqN survives.
REQ-024 Killed buffers SHALL be cleared at the edge and are not granted that cycle.
REQ-025 Killed inputs SHALL NOT be captured.
REQ-026 A killed entry in the output register SHALL drop OUT_valid at the next edge.
REQ-027 OUT_sqN/OUT_tag/OUT_result/OUT_grantIdx SHALL be don't-care while OUT_valid=0.

Reset
REQ-028 With rst=0 at an edge, all buffers SHALL become empty and OUT_valid=0; OUT_stall SHALL read 0 the following cycle.
REQ-029 Reset mid-operation SHALL discard all held and in-flight entries without emitting them.

Configuration
REQ-030 With WBARB_STARVE_GUARD_EN defined, each requester SHALL have a 3-bit counter.
REQ-031 The counter SHALL increment while the buffer is full and not granted, and clear on grant, kill or reset.
REQ-032 When any counter reaches 4, the lowest such index SHALL be granted regardless of age.
REQ-033 Without WBARB_STARVE_GUARD_EN, grant SHALL be pure oldest-first per REQ-020 and no counters exist.

Verification
REQ-034 Scenario: single req0 sqN=5 tag=3 result=0xDEADBEEF at cycle 0 -> OUT_valid at cycle 2 with those fields, grantIdx=0.
REQ-035 Scenario: req0 sqN=10, req1 sqN=8, req2 sqN=9 in the same cycle -> grants in order 1,2,0 on consecutive cycles; OUT_stall[0] high 2 cycles, OUT_stall[2] high 1 cycle.
REQ-036 Scenario: wrap, req0 sqN=126, req1 sqN=1 (SQN_W=7) -> req0 granted first.
REQ-037 Scenario: buffers hold sqN 3,6,9; invalidate with IN_invalidateSqN=6 -> only sqN 3 and 6 emitted; input sqN=7 in the flush cycle not captured.
REQ-038 Scenario: rst=0 while all three buffers are full -> no OUT_valid afterwards; stalls clear.
REQ-039 Scenario (guard on): req0 fed continuously with older sqN while req2 is held -> req2 granted no later than the 5th cycle after capture; guard off -> req2 waits until req0 idles.
